// File: rtl/conv_pool_mc.sv
// conv_pool_mc: streaming multi-channel 3x3 convolution over 4x4 tiles,
// producing a 2x2 result per tile that is max- or average-pooled, shifted
// right by SHIFT and saturated to an unsigned byte.
// Read -> write latency is a fixed 3 cycles:
//   read issue -> tile capture (conv) -> pool/saturate -> write.
// Optional feature: define CONV_POOL_RELU_EN to clamp each convolution
// output at 0 before pooling. The default build pools the signed outputs.
module conv_pool_mc #(
   parameter int CH     = 3,
   parameter int NTILES = 65025,
   parameter int ADDR_W = 16,
   parameter int SHIFT  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pool_mode,
   input  logic [CH*128-1:0]   image_4x4,
   input  logic [CH*72-1:0]    kernel,
   output logic                input_re,
   output logic [ADDR_W-1:0]   input_addr,
   output logic                output_we,
   output logic [ADDR_W-1:0]   output_addr,
   output logic [7:0]          y,
   output logic                busy,
   output logic                done
);

   // Accumulator sized so 9*CH products of u8 x s8 can never overflow;
   // two more bits hold the four-way sum used by average pooling.
   localparam int ACC_W  = 17 + $clog2(9 * CH);
   localparam int POOL_W = ACC_W + 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTILES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t                    state_q;
   logic                      mode_q;
   logic                      input_re_q;
   logic [ADDR_W-1:0]         input_addr_q;
   logic                      busy_q;
   logic                      done_q;

   logic                      vld_p0;
   logic                      vld_p1;
   logic [ADDR_W-1:0]         addr_p0;
   logic [ADDR_W-1:0]         addr_p1;
   logic signed [ACC_W-1:0]   conv_d  [4];
   logic signed [ACC_W-1:0]   conv_p1 [4];
   logic signed [POOL_W-1:0]  pool_d;

   logic                      output_we_q;
   logic [ADDR_W-1:0]         output_addr_q;
   logic [7:0]                y_q;

   logic signed [8:0]         pix;
   logic signed [7:0]         cf;
   logic signed [16:0]        prod;

   // Optional rectification of one convolution output, widened to pool width.
   function automatic logic signed [POOL_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef CONV_POOL_RELU_EN
      return v[ACC_W-1] ? '0 : POOL_W'(v);
`else
      return POOL_W'(v);
`endif
   endfunction

   // Max (mode 0) or floor-average (mode 1) of the four outputs.
   function automatic logic signed [POOL_W-1:0] pool4(
      input logic                     mode,
      input logic signed [POOL_W-1:0] a,
      input logic signed [POOL_W-1:0] b,
      input logic signed [POOL_W-1:0] c,
      input logic signed [POOL_W-1:0] d
   );
      logic signed [POOL_W-1:0] m;
      logic signed [POOL_W-1:0] s;
      s = a + b + c + d;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return mode ? (s >>> 2) : m;
   endfunction

   // Post-pool arithmetic shift, then clamp to the unsigned byte range.
   function automatic logic [7:0] sat_u8(input logic signed [POOL_W-1:0] v);
      logic signed [POOL_W-1:0] s;
      s = v >>> SHIFT;
      if (s[POOL_W-1])               return 8'd0;
      else if (s > POOL_W'(255))     return 8'd255;
      else                           return s[7:0];
   endfunction

   // 2x2 valid convolution of the tile currently on image_4x4, summed over channels.
   always_comb begin
      pix  = '0;
      cf   = '0;
      prod = '0;
      for (int o = 0; o < 4; o++) begin
         conv_d[o] = '0;
         for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  pix  = {1'b0, image_4x4[c*128 + (((o/2)+i)*4 + (o%2) + j)*8 +: 8]};
                  cf   = kernel[c*72 + (i*3+j)*8 +: 8];
                  prod = 17'(pix) * 17'(cf);
                  conv_d[o] = conv_d[o] + ACC_W'(prod);
               end
            end
         end
      end
   end

   // Pooling of the captured convolution outputs.
   always_comb begin
      pool_d = pool4(mode_q, relu(conv_p1[0]), relu(conv_p1[1]),
                     relu(conv_p1[2]), relu(conv_p1[3]));
   end

   // Frame sequencer: issues reads, waits for the last write, pulses done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= 1'b0;
         input_re_q   <= 1'b0;
         input_addr_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q      <= RUN;
                  mode_q       <= pool_mode;
                  input_re_q   <= 1'b1;
                  input_addr_q <= '0;
                  busy_q       <= 1'b1;
               end
            end
            RUN: begin
               if (input_addr_q == LAST_ADDR) begin
                  state_q      <= DRAIN;
                  input_re_q   <= 1'b0;
                  input_addr_q <= '0;
               end else begin
                  input_addr_q <= input_addr_q + 1'b1;
               end
            end
            DRAIN: begin
               if (output_we_q && (output_addr_q == LAST_ADDR)) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FIN: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Valid chain and registered write port; outputs idle at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0        <= 1'b0;
         vld_p1        <= 1'b0;
         output_we_q   <= 1'b0;
         output_addr_q <= '0;
         y_q           <= '0;
      end else begin
         vld_p0        <= input_re_q;
         vld_p1        <= vld_p0;
         output_we_q   <= vld_p1;
         output_addr_q <= vld_p1 ? addr_p1 : '0;
         y_q           <= vld_p1 ? sat_u8(pool_d) : '0;
      end
   end

   // Data pipeline, p0: address of the tile arriving on image_4x4.
   // p1: convolution outputs and their address.
   always_ff @(posedge clk) begin
      addr_p0 <= input_addr_q;
      addr_p1 <= addr_p0;
      for (int o = 0; o < 4; o++) conv_p1[o] <= conv_d[o];
   end

   assign input_re    = input_re_q;
   assign input_addr  = input_addr_q;
   assign output_we   = output_we_q;
   assign output_addr = output_addr_q;
   assign y           = y_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_conv_pool_mc.sv
// Directed bench for conv_pool_mc: two instances (SHIFT=0 and SHIFT=1) run in
// lockstep against a 1-cycle-latency tile memory model.
module tb_conv_pool_mc;

   localparam int CH = 3;
   localparam int NT = 16;
   localparam int AW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              pool_mode;
   logic [CH*128-1:0] image_4x4;
   logic [CH*72-1:0]  kernel;

   logic              input_re, output_we, busy, done;
   logic [AW-1:0]     input_addr, output_addr;
   logic [7:0]        y;

   logic              sh_re, sh_we, sh_busy, sh_done;
   logic [AW-1:0]     sh_iaddr, sh_oaddr;
   logic [7:0]        sh_y;

   conv_pool_mc #(.CH(CH), .NTILES(NT), .ADDR_W(AW), .SHIFT(0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .pool_mode(pool_mode),
      .image_4x4(image_4x4), .kernel(kernel),
      .input_re(input_re), .input_addr(input_addr),
      .output_we(output_we), .output_addr(output_addr),
      .y(y), .busy(busy), .done(done)
   );

   conv_pool_mc #(.CH(CH), .NTILES(NT), .ADDR_W(AW), .SHIFT(1)) u_sh (
      .clk(clk), .rst(rst), .start(start), .pool_mode(pool_mode),
      .image_4x4(image_4x4), .kernel(kernel),
      .input_re(sh_re), .input_addr(sh_iaddr),
      .output_we(sh_we), .output_addr(sh_oaddr),
      .y(sh_y), .busy(sh_busy), .done(sh_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Tile memory model: pattern 0 = constant pv, 1 = pixel equals address,
   // 2 = row 0 holds 100,200,0,0 and all else 0.
   int pat = 0;
   int pv  = 0;

   function automatic logic [CH*128-1:0] mk_img(input logic [AW-1:0] a);
      logic [CH*128-1:0] v;
      logic [31:0]       p32;
      v   = '0;
      p32 = pv;
      for (int c = 0; c < CH; c++)
         for (int p = 0; p < 16; p++)
            case (pat)
               0: v[c*128 + p*8 +: 8] = p32[7:0];
               1: v[c*128 + p*8 +: 8] = a[7:0];
               default: v[c*128 + p*8 +: 8] = (p == 0) ? 8'd100 : (p == 1) ? 8'd200 : 8'd0;
            endcase
      return v;
   endfunction

   always @(posedge clk) begin
      if (input_re) image_4x4 <= mk_img(input_addr);
   end

   task automatic set_kernel_all(input int kv);
      logic [31:0] k32;
      k32 = kv;
      for (int c = 0; c < CH; c++)
         for (int t = 0; t < 9; t++)
            kernel[c*72 + t*8 +: 8] = k32[7:0];
   endtask

   // Recorded observations.
   logic rec_en = 1'b0;
   int re_cnt, re_first, re_err, exp_ra;
   int we_cnt, we_first, done_cnt, done_cyc, busy_cnt, idle_nz;
   logic busy_at_done;
   int wcnt [NT];
   int ygot [NT];
   int ysh  [NT];
   int exp_y  [NT];
   int exp_sh [NT];

   always @(negedge clk) begin
      if (rec_en) begin
         if (input_re) begin
            if (re_cnt == 0) re_first = cyc;
            if (input_addr != AW'(exp_ra)) re_err++;
            exp_ra++;
            re_cnt++;
         end
         if (output_we) begin
            if (we_cnt == 0) we_first = cyc;
            we_cnt++;
            if (output_addr < AW'(NT)) begin
               wcnt[output_addr]++;
               ygot[output_addr] = y;
            end
         end
         if (sh_we && sh_oaddr < AW'(NT)) ysh[sh_oaddr] = sh_y;
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
         end
         if (busy) busy_cnt++;
         if (!input_re && !output_we && (input_addr != 0 || output_addr != 0 || y != 0))
            idle_nz++;
      end
   end

   task automatic clear_rec();
      re_cnt = 0; re_first = -1; re_err = 0; exp_ra = 0;
      we_cnt = 0; we_first = -1; done_cnt = 0; done_cyc = -1;
      busy_cnt = 0; idle_nz = 0; busy_at_done = 1'b1;
      for (int a = 0; a < NT; a++) begin
         wcnt[a] = 0; ygot[a] = -1; ysh[a] = -1;
      end
      rec_en = 1'b1;
   endtask

   task automatic run_frame(input string name, input logic mode, input logic restart);
      int s;
      @(posedge clk);
      clear_rec();
      @(negedge clk);
      s         = cyc;
      start     = 1'b1;
      pool_mode = mode;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 400 && done_cnt == 0; n++) begin
         @(negedge clk);
         start = restart && (cyc == s + 3);
      end
      start = 1'b0;
      repeat (10) @(negedge clk);
      check_val({name, " re_first"}, re_first, s + 1);
      check_val({name, " re_cnt"}, re_cnt, NT);
      check_val({name, " re_addr_seq"}, re_err, 0);
      check_val({name, " we_first"}, we_first, s + 4);
      check_val({name, " we_cnt"}, we_cnt, NT);
      check_val({name, " done_cnt"}, done_cnt, 1);
      check_val({name, " done_cyc"}, done_cyc, s + NT + 4);
      check_val({name, " busy_at_done"}, busy_at_done, 0);
      check_val({name, " busy_cnt"}, busy_cnt, NT + 3);
      check_val({name, " idle_zero"}, idle_nz, 0);
      for (int a = 0; a < NT; a++) begin
         check_val($sformatf("%s wcnt[%0d]", name, a), wcnt[a], 1);
         check_val($sformatf("%s y[%0d]", name, a), ygot[a], exp_y[a]);
         check_val($sformatf("%s ysh[%0d]", name, a), ysh[a], exp_sh[a]);
      end
   endtask

   task automatic fill_exp(input int ev, input int es);
      for (int a = 0; a < NT; a++) begin
         exp_y[a]  = ev;
         exp_sh[a] = es;
      end
   endtask

   task automatic fill_ramp();
      for (int a = 0; a < NT; a++) begin
         exp_y[a]  = (27 * a > 255) ? 255 : 27 * a;
         exp_sh[a] = ((27 * a) / 2 > 255) ? 255 : (27 * a) / 2;
      end
   endtask

   int w_snap;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      pool_mode = 1'b0;
      kernel    = '0;
      image_4x4 = '0;
      repeat (3) @(negedge clk);
      check_val("rst input_re", input_re, 0);
      check_val("rst output_we", output_we, 0);
      check_val("rst busy", busy, 0);
      check_val("rst done", done, 0);
      check_val("rst input_addr", input_addr, 0);
      check_val("rst output_addr", output_addr, 0);
      check_val("rst y", y, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // All ones: 27 per output; second start during busy is ignored.
      pat = 0; pv = 1; set_kernel_all(1);
      fill_exp(27, 13);
      run_frame("ones_max", 1'b0, 1'b1);
      run_frame("ones_avg", 1'b1, 1'b0);

      // 255 x 127 x 27 = 874395 saturates high.
      pv = 255; set_kernel_all(127);
      fill_exp(255, 255);
      run_frame("sat_hi", 1'b0, 1'b0);

      // 10 x -1 x 27 = -270 saturates low.
      pv = 10; set_kernel_all(-1);
      fill_exp(0, 0);
      run_frame("sat_lo", 1'b0, 1'b0);

      // Pixel = tile address: y = min(27k, 255), ties address to data.
      pat = 1; set_kernel_all(1);
      fill_ramp();
      run_frame("ramp_max", 1'b0, 1'b0);

      // Outputs {-100,200,0,0}: coef(0,0)=1, coef(0,1)=-1 on channel 0 only.
      pat = 2; kernel = '0;
      kernel[7:0]  = 8'd1;
      kernel[15:8] = 8'hFF;
`ifdef CONV_POOL_RELU_EN
      fill_exp(50, 25);
`else
      fill_exp(25, 12);
`endif
      run_frame("mix_avg", 1'b1, 1'b0);
      fill_exp(200, 100);
      run_frame("mix_max", 1'b0, 1'b0);

      // Reset in cycle 3 of a frame aborts it.
      pat = 1; set_kernel_all(1);
      @(posedge clk);
      clear_rec();
      @(negedge clk);
      start = 1'b1; pool_mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("abort input_re", input_re, 0);
      check_val("abort output_we", output_we, 0);
      check_val("abort busy", busy, 0);
      check_val("abort done", done, 0);
      check_val("abort input_addr", input_addr, 0);
      check_val("abort output_addr", output_addr, 0);
      check_val("abort y", y, 0);
      @(negedge clk);
      rst    = 1'b0;
      w_snap = we_cnt;
      repeat (30) @(negedge clk);
      check_val("abort no_we", we_cnt, w_snap);
      check_val("abort idle_busy", busy, 0);
      fill_ramp();
      run_frame("after_rst", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv_pool_mc.md
CONV_POOL_MC -- requirements
Module: conv_pool_mc

Interface
REQ-001 Parameter CH, default 3: number of input channels, 1..8.
REQ-002 Parameter NTILES, default 65025: 4x4 tiles per frame.
REQ-003 Parameter ADDR_W, default 16: width of input_addr and output_addr.
REQ-004 Parameter SHIFT, default 0: arithmetic right shift applied after pooling, 0..15.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit: one-cycle pulse that begins a frame.
REQ-008 Port pool_mode, input, 1 bit: 0 selects max pooling, 1 selects average pooling; sampled when start is accepted.
REQ-009 Port image_4x4, input, CH*128 bits: channel c occupies bits [c*128 +: 128]; pixel (r,x) is unsigned 8-bit at [(r*4+x)*8 +: 8].
REQ-010 Port kernel, input, CH*72 bits: channel c occupies bits [c*72 +: 72]; coefficient (i,j) is signed 8-bit at [(i*3+j)*8 +: 8]; held static during a frame.
REQ-011 Port input_re, output, 1 bit: tile read enable.
REQ-012 Port input_addr, output, ADDR_W bits: tile read address.
REQ-013 Port output_we, output, 1 bit: result write enable.
REQ-014 Port output_addr, output, ADDR_W bits: result write address.
REQ-015 Port y, output, 8 bits: pooled result.
REQ-016 Port busy, output, 1 bit: high from start acceptance until done.
REQ-017 Port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-018 The FSM SHALL use states IDLE, RUN, DRAIN and FIN; start in IDLE moves to RUN, the last read moves RUN to DRAIN, the last write moves DRAIN to FIN, and FIN returns to IDLE after one cycle.
REQ-019 In RUN, input_re SHALL be high on consecutive cycles with input_addr = 0, 1, ..., NTILES-1, one tile per cycle, without gaps.
REQ-020 Memory read latency is 1 cycle: tile data for the read issued in cycle c SHALL be sampled from image_4x4 in cycle c+1.
REQ-021 For the read of tile k issued in cycle c, output_we SHALL be high in cycle c+3 with output_addr = k; this is a fixed 3-stage pipeline.
REQ-022 Per tile, the block SHALL compute 2x2 valid convolution outputs. Each output is the sum over all channels and all 9 taps of pixel times coefficient, held in a signed accumulator at least 17+clog2(9*CH) bits wide with no overflow.
REQ-023 Max pooling SHALL select the largest signed value of the four outputs. Average pooling SHALL compute the sum of the four outputs arithmetically shifted right by 2 (floor).
REQ-024 The pooled value SHALL then be arithmetically shifted right by SHIFT and saturated to [0,255] to form y.
REQ-025 done SHALL pulse in the cycle after the last output_we; busy SHALL be low in that cycle.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 When neither input_re nor output_we is active, input_addr, output_addr and y SHALL be 0.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE; input_re, output_we, busy, done, input_addr, output_addr and y SHALL be 0; pipeline valid bits SHALL be cleared.
REQ-029 Reset asserted during RUN or DRAIN SHALL abort the frame immediately, and no write SHALL occur after rst deasserts until a new start.

Configuration
REQ-030 With CONV_POOL_RELU_EN defined, each of the four convolution outputs SHALL be clamped to a minimum of 0 before pooling.
REQ-031 Without CONV_POOL_RELU_EN, pooling SHALL operate on the signed convolution outputs, and only the final saturation of REQ-024 clamps negative values.

Verification
REQ-032 CH=3, all pixels 1, all coefficients 1, SHIFT=0, max mode, NTILES=16: every y=27, addresses 0..15 written once each, done pulses once.
REQ-033 All pixels 255, all coefficients 127, CH=3: raw sum 874395 gives y=255 (saturation); coefficients -1 with pixels 10 give y=0.
REQ-034 Tile and kernel chosen to give convolution outputs {-100,200,0,0} in average mode, SHIFT=0: y=50 with CONV_POOL_RELU_EN defined and y=25 without it; in max mode y=200 in both builds.
REQ-035 NTILES=4, start issued in cycle 0: input_re high in cycles 1-4, output_we high in cycles 4-7, done high in cycle 8, busy high in cycles 1-7; a second start in cycle 3 is ignored.
REQ-036 rst pulsed in cycle 3 of a NTILES=100 frame: all outputs 0 immediately, no output_we afterwards, and a new start runs a full, correct frame.
